// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: per-cycle advance/hold/flush control for the 5-stage MIPS pipeline
// Ports: i_clock/i_reset (async, active-high); i_start, i_mode_step, i_step run/step debug control;
// i_halt, i_jump, i_branch_taken, load-use operands as hazard inputs;
// o_pc_enable, o_IF_ID_enable, o_pipe_enable, o_IF_ID_flush, o_ID_EX_flush drive the stages;
// o_halted, o_busy, o_cycle_count report status.
module pipeline_sequencer #(
  parameter int NB_REG       = 5,
  parameter int NB_COUNT     = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_mode_step,
  input  logic                i_step,
  input  logic                i_halt,
  input  logic                i_jump,
  input  logic                i_branch_taken,
  input  logic                i_ID_EX_mem_read,
  input  logic [NB_REG-1:0]   i_ID_EX_rt,
  input  logic [NB_REG-1:0]   i_IF_ID_rs,
  input  logic [NB_REG-1:0]   i_IF_ID_rt,
  output logic                o_pc_enable,
  output logic                o_IF_ID_enable,
  output logic                o_pipe_enable,
  output logic                o_IF_ID_flush,
  output logic                o_ID_EX_flush,
  output logic                o_halted,
  output logic                o_busy,
  output logic [NB_COUNT-1:0] o_cycle_count
);
  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
  state_t state, state_nxt;
  logic [NB_DRAIN-1:0] drain_cnt, drain_nxt;
  logic step_prev, stall, advance;
  assign advance = state == RUN || state == STEP;
  assign stall = i_ID_EX_mem_read && i_ID_EX_rt != '0 &&
                 (i_ID_EX_rt == i_IF_ID_rs || i_ID_EX_rt == i_IF_ID_rt);
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      step_prev     <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      step_prev <= i_step;
      if (o_busy && !(&o_cycle_count)) o_cycle_count <= o_cycle_count + 1'b1;
    end
  end
  always_comb begin
    state_nxt      = state;
    drain_nxt      = drain_cnt;
    o_pc_enable    = 1'b0;
    o_IF_ID_enable = 1'b0;
    o_pipe_enable  = 1'b0;
    o_IF_ID_flush  = 1'b0;
    o_ID_EX_flush  = 1'b0;
    o_busy         = advance || state == DRAIN;
    o_halted       = state == HALTED;
    if (o_busy) begin
      if (i_branch_taken) begin
        o_pc_enable    = 1'b1;
        o_IF_ID_enable = 1'b1;
        o_pipe_enable  = 1'b1;
        o_IF_ID_flush  = 1'b1;
        o_ID_EX_flush  = 1'b1;
      end else if (state == DRAIN || (!stall && i_halt)) begin
        o_pipe_enable = 1'b1;
        o_IF_ID_flush = 1'b1;
      end else if (stall) begin
        o_pipe_enable = 1'b1;
        o_ID_EX_flush = 1'b1;
      end else begin
        o_pc_enable    = 1'b1;
        o_IF_ID_enable = 1'b1;
        o_pipe_enable  = 1'b1;
        o_IF_ID_flush  = i_jump;
      end
    end
    case (state)
      IDLE:
        state_nxt = (i_start && !i_mode_step) ? RUN :
                    (i_step && !step_prev && i_mode_step) ? STEP : IDLE;
      RUN, STEP:
        if (!i_branch_taken && !stall && i_halt) begin
          state_nxt = DRAIN;
          drain_nxt = NB_DRAIN'(DRAIN_CYCLES);
        end else begin
          state_nxt = (state == STEP || i_mode_step) ? IDLE : RUN;
        end
      DRAIN:
        if (i_branch_taken) begin
          state_nxt = i_mode_step ? IDLE : RUN;
        end else begin
          state_nxt = drain_cnt == NB_DRAIN'(1) ? HALTED : DRAIN;
          drain_nxt = drain_cnt - 1'b1;
        end
      default: state_nxt = state;
    endcase
  end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: scoreboard bench for pipeline_sequencer against a behavioural model
module tb_pipeline_sequencer;
  localparam int NB_REG = 5;
  localparam int NB_COUNT = 32;
  localparam int DRAIN_N = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;
  logic i_clock = 1'b0;
  logic i_reset, i_start, i_mode_step, i_step, i_halt, i_jump, i_branch_taken, i_ID_EX_mem_read;
  logic [NB_REG-1:0] i_ID_EX_rt, i_IF_ID_rs, i_IF_ID_rt;
  logic o_pc_enable, o_IF_ID_enable, o_pipe_enable, o_IF_ID_flush, o_ID_EX_flush, o_halted, o_busy;
  logic [NB_COUNT-1:0] o_cycle_count;
  typedef struct {
    logic [6:0]          f;
    logic [6:0]          care;
    logic [NB_COUNT-1:0] count;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int m_state = M_IDLE;
  int m_left = 0;
  longint m_count = 0;
  bit m_prev = 1'b0;
  pipeline_sequencer #(.NB_REG(NB_REG), .NB_COUNT(NB_COUNT), .DRAIN_CYCLES(DRAIN_N)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_mode_step(i_mode_step),
    .i_step(i_step), .i_halt(i_halt), .i_jump(i_jump), .i_branch_taken(i_branch_taken),
    .i_ID_EX_mem_read(i_ID_EX_mem_read), .i_ID_EX_rt(i_ID_EX_rt), .i_IF_ID_rs(i_IF_ID_rs),
    .i_IF_ID_rt(i_IF_ID_rt), .o_pc_enable(o_pc_enable), .o_IF_ID_enable(o_IF_ID_enable),
    .o_pipe_enable(o_pipe_enable), .o_IF_ID_flush(o_IF_ID_flush), .o_ID_EX_flush(o_ID_EX_flush),
    .o_halted(o_halted), .o_busy(o_busy), .o_cycle_count(o_cycle_count)
  );
  always #5 i_clock = ~i_clock;
  function automatic logic [6:0] outs();
    return {o_pc_enable, o_IF_ID_enable, o_pipe_enable, o_IF_ID_flush, o_ID_EX_flush, o_halted, o_busy};
  endfunction
  always @(negedge i_clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ((outs() & e.care) !== (e.f & e.care)) begin
        failures++;
        $display("FAIL flags t=%0t got=%b want=%b care=%b", $time, outs(), e.f, e.care);
      end
      checks++;
      if (o_cycle_count !== e.count) begin
        failures++;
        $display("FAIL cycle_count t=%0t got=%0d want=%0d", $time, o_cycle_count, e.count);
      end
    end
  end
  task automatic model_reset();
    m_state = M_IDLE;
    m_left = 0;
    m_count = 0;
    m_prev = 1'b0;
  endtask
  task automatic cycle(input bit rst, start, mstep, step, halt, jump, br, mr,
                       input logic [NB_REG-1:0] exrt, rs, rt);
    exp_t e;
    bit busy, hazard, halt_taken;
    bit pc, ie, pe, fi, fe;
    @(posedge i_clock);
    #1;
    i_reset = rst; i_start = start; i_mode_step = mstep; i_step = step; i_halt = halt;
    i_jump = jump; i_branch_taken = br; i_ID_EX_mem_read = mr;
    i_ID_EX_rt = exrt; i_IF_ID_rs = rs; i_IF_ID_rt = rt;
    e.care = 7'h7f;
    if (rst) begin
      model_reset();
      e.f = '0;
      e.count = '0;
      q.push_back(e);
      return;
    end
    busy = m_state == M_RUN || m_state == M_STEP || m_state == M_DRAIN;
    hazard = mr && exrt != 0 && (exrt == rs || exrt == rt);
    halt_taken = (m_state == M_RUN || m_state == M_STEP) && !br && !hazard && halt;
    {pc, ie, pe, fi, fe} = 5'b0;
    if (busy) begin
      if (br) {pc, ie, pe, fi, fe} = 5'b11111;
      else if (m_state == M_DRAIN || halt_taken) begin
        pe = 1; fi = 1; e.care[5] = 1'b0;
      end else if (hazard) begin
        pe = 1; fe = 1;
      end else begin
        pc = 1; ie = 1; pe = 1; fi = jump;
      end
    end
    e.f = {pc, ie, pe, fi, fe, m_state == M_HALTED, busy};
    e.count = m_count[NB_COUNT-1:0];
    q.push_back(e);
    if (busy && m_count < 64'hFFFF_FFFF) m_count++;
    if (m_state == M_IDLE) begin
      if (start && !mstep) m_state = M_RUN;
      else if (step && !m_prev && mstep) m_state = M_STEP;
    end else if (m_state == M_DRAIN) begin
      if (br) m_state = mstep ? M_IDLE : M_RUN;
      else begin
        m_left--;
        if (m_left == 0) m_state = M_HALTED;
      end
    end else if (m_state != M_HALTED) begin
      if (halt_taken) begin
        m_state = M_DRAIN;
        m_left = DRAIN_N;
      end else if (m_state == M_STEP || mstep) m_state = M_IDLE;
    end
    m_prev = step;
  endtask
  task automatic idle_c(input bit rst, start, mstep, step);
    cycle(rst, start, mstep, step, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic run_c(input bit halt, jump, br);
    cycle(0, 1, 0, 0, halt, jump, br, 0, 0, 0, 0);
  endtask
  task automatic mid_reset();
    @(negedge i_clock);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0 || o_cycle_count !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d want=0000000/0", outs(), o_cycle_count);
    end
    model_reset();
  endtask
  initial begin
    i_reset = 1; i_start = 0; i_mode_step = 0; i_step = 0; i_halt = 0; i_jump = 0;
    i_branch_taken = 0; i_ID_EX_mem_read = 0; i_ID_EX_rt = 0; i_IF_ID_rs = 0; i_IF_ID_rt = 0;
    repeat (2) idle_c(1, 0, 0, 0);
    repeat (11) run_c(0, 0, 0);
    run_c(0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    cycle(0, 1, 0, 0, 1, 0, 0, 1, 5, 0, 5);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    run_c(1, 0, 0);
    repeat (3) run_c(0, 0, 0);
    repeat (3) run_c(0, 0, 0);
    idle_c(1, 0, 0, 0);
    repeat (2) run_c(0, 0, 0);
    run_c(1, 0, 1);
    run_c(0, 0, 0);
    run_c(1, 0, 0);
    run_c(0, 0, 0);
    run_c(0, 0, 1);
    repeat (2) run_c(0, 0, 0);
    idle_c(1, 0, 0, 0);
    repeat (5) idle_c(0, 0, 1, 1);
    repeat (2) idle_c(0, 0, 1, 0);
    repeat (2) idle_c(0, 0, 1, 1);
    repeat (2) idle_c(0, 1, 1, 0);
    idle_c(1, 0, 0, 0);
    run_c(0, 0, 0);
    run_c(1, 0, 0);
    run_c(0, 0, 0);
    mid_reset();
    idle_c(1, 1, 0, 0);
    repeat (3) run_c(0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(99) == 0, $urandom_range(1), $urandom_range(3) == 0,
            $urandom_range(1), $urandom_range(15) == 0, $urandom_range(7) == 0,
            $urandom_range(7) == 0, $urandom_range(3) == 0,
            NB_REG'($urandom_range(3)), NB_REG'($urandom_range(3)), NB_REG'($urandom_range(3)));
    @(negedge i_clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central sequencer for the 5-stage MIPS pipeline: decides each cycle whether the PC and each inter-stage latch advance, hold or flush. Combines run/single-step debug control, load-use stall, jump/branch flush and halt drain. Sits beside the stages and drives their enable/flush pins, including the decode stage's enable.

## Interface
- NB_REG, 5, register address width
- NB_COUNT, 32, cycle counter width
- DRAIN_CYCLES, 3, cycles needed to retire instructions already past ID after halt

- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high
- i_start  in  1  level; begin continuous run from IDLE
- i_mode_step  in  1  1 = single-step mode, 0 = continuous
- i_step  in  1  step request; one step per rising edge
- i_halt  in  1  halt opcode currently decoded in ID
- i_jump  in  1  j/jal/jr/jalr decoded in ID
- i_branch_taken  in  1  branch resolved taken at EX/MEM
- i_ID_EX_mem_read  in  1  load in EX
- i_ID_EX_rt  in  NB_REG  load destination
- i_IF_ID_rs, i_IF_ID_rt  in  NB_REG  sources of instruction in ID
- o_pc_enable  out  1
- o_IF_ID_enable  out  1
- o_pipe_enable  out  1  ID/EX, EX/MEM, MEM/WB enable (also ID stage enable)
- o_IF_ID_flush, o_ID_EX_flush  out  1  load bubble into latch this cycle
- o_halted  out  1
- o_busy  out  1  state in RUN, STEP or DRAIN
- o_cycle_count  out  NB_COUNT  active-cycle counter

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Reset -> IDLE.
- IDLE: all enables/flushes 0. i_start & !i_mode_step -> RUN. Rising edge of i_step (registered previous value) & i_mode_step -> STEP.
- RUN: advance each cycle; if i_mode_step=1 -> IDLE (pause, current cycle still advances).
- STEP: exactly one advance cycle, then IDLE. Held i_step gives no further steps until it falls and rises again.
- Advance cycle (RUN or STEP), priority high to low:
  - i_branch_taken: pc/IF_ID/pipe enable 1, IF_ID_flush=1, ID_EX_flush=1. i_halt and stall ignored.
  - load-use stall (i_ID_EX_mem_read & i_ID_EX_rt!=0 & (rt==rs | rt==rt)): pc_enable=0, IF_ID_enable=0, pipe_enable=1, ID_EX_flush=1. i_halt deferred.
  - i_halt: pc_enable=0, IF_ID_flush=1, pipe_enable=1; next state DRAIN, counter=DRAIN_CYCLES.
  - i_jump: all enables 1, IF_ID_flush=1.
  - else all enables 1, no flush.
- DRAIN: pc_enable=0, IF_ID_flush=1, pipe_enable=1; counter decrements; counter==1 -> HALTED. Runs regardless of i_mode_step. i_branch_taken during DRAIN: halt was wrong-path; apply branch flush, go to RUN (or IDLE if i_mode_step).
- HALTED: all enables/flushes 0, o_halted=1; exits only via i_reset.
- o_cycle_count: +1 each cycle in RUN, STEP, DRAIN; saturates at all-ones.

## Timing
- All outputs combinational from state and same-cycle inputs; hazard response zero latency.
- State, counters, step-edge register update on rising i_clock.
- Reset (any time, incl. mid-DRAIN): state IDLE, all enables/flushes 0, o_halted=0, o_busy=0, o_cycle_count=0, step-edge register 0.
- Halt to o_halted: DRAIN_CYCLES+1 cycles after halt cycle with no branch.
- Flush and enable of same latch both 1: flush wins (latch loads bubble).

## Test plan
- Continuous run, no hazards, i_start=1: all enables 1 every cycle, o_cycle_count=10 after 10 cycles.
- Load-use: mem_read=1, ID_EX_rt=5, IF_ID_rs=5 -> pc_enable=0, IF_ID_enable=0, ID_EX_flush=1, pipe_enable=1; rt=0 -> no stall.
- Halt: i_halt for one RUN cycle -> 3 DRAIN cycles (pc_enable=0, pipe_enable=1), then o_halted=1, count frozen; i_start ignored.
- Branch over halt: i_halt and i_branch_taken same cycle -> stays RUN, both flushes 1; branch during DRAIN cycle 2 -> RUN, no o_halted.
- Step mode: i_step held high 5 cycles -> exactly one advance cycle; second rising edge -> second cycle; o_cycle_count=2.
- Reset asserted asynchronously mid-DRAIN -> outputs at reset values immediately, before next clock edge.
